// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transfer controller: FSM state encoding and
// default parameter values used by spi_xfer_ctrl and spi_xfer_shift.
package spi_pkg;

  localparam int MAX_CHAR_DEF = 32;
  localparam int DIV_W_DEF    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    XFER  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/spi_xfer_shift.sv
// Transmit/receive shift datapath for spi_xfer_ctrl. Handles bit order:
// MSB-first words are left-aligned on load so mosi always comes from the top
// bit; LSB-first receive words are right-aligned when the final bit arrives,
// so the first received bit lands where the first transmitted bit came from.
module spi_xfer_shift #(
  parameter int MAX_CHAR = spi_pkg::MAX_CHAR_DEF,
  parameter int CW       = $clog2(MAX_CHAR) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                load_lsb,
  input  logic [CW-1:0]       load_len,
  input  logic [MAX_CHAR-1:0] load_data,
  input  logic                advance,
  input  logic                sample,
  input  logic                capture,
  input  logic                miso,
  output logic                mosi,
  output logic [MAX_CHAR-1:0] rsp_data
);

  logic [MAX_CHAR-1:0] tx_sr;
  logic [MAX_CHAR-1:0] rx_sr;
  logic [MAX_CHAR-1:0] rx_next;
  logic                lsb;
  logic [CW-1:0]       len;
  logic [CW-1:0]       pad;

  assign pad     = CW'(MAX_CHAR) - len;
  assign rx_next = lsb ? {miso, rx_sr[MAX_CHAR-1:1]} : {rx_sr[MAX_CHAR-2:0], miso};
  assign mosi    = lsb ? tx_sr[0] : tx_sr[MAX_CHAR-1];

  // Load a new word on acceptance, then shift tx on tx edges and rx on rx edges.
  // NOTE: the shift registers are reset (not left undefined) because mosi and
  // rsp_data are driven straight from them and must read 0 after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_sr <= '0;
      rx_sr <= '0;
      lsb   <= 1'b0;
      len   <= '0;
    end else if (load) begin
      // NOTE: non-blocking assignments let every register here see the
      // pre-edge values, so tx advance and rx sample in one cycle don't race.
      lsb   <= load_lsb;
      len   <= load_len;
      rx_sr <= '0;
      tx_sr <= load_lsb ? load_data : (load_data << (CW'(MAX_CHAR) - load_len));
    end else begin
      if (advance) tx_sr <= lsb ? (tx_sr >> 1) : (tx_sr << 1);
      if (sample)  rx_sr <= rx_next;
    end
  end

  // Capture the completed word, including the bit arriving on the final edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          rsp_data <= '0;
    else if (capture) rsp_data <= lsb ? (rx_next >> pad) : rx_next;
  end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI transfer controller: accepts a request, drives an external SPI clock
// generator, shifts one word out on mosi and in from miso, and returns the
// received word through a valid/ready response.
// Optional build macro SPI_XFER_CTRL_IRQ_EN adds irq_o, raised with the
// response and cleared on the response handshake.
module spi_xfer_ctrl
  import spi_pkg::*;
#(
  parameter int MAX_CHAR = MAX_CHAR_DEF,
  parameter int DIV_W    = DIV_W_DEF
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [$clog2(MAX_CHAR)-1:0] req_len_i,
  input  logic [MAX_CHAR-1:0]         req_data_i,
  input  logic [DIV_W-1:0]            req_div_i,
  input  logic                        req_lsb_i,
  input  logic                        req_tx_neg_i,
  input  logic                        req_rx_neg_i,
  output logic                        rsp_valid_o,
  input  logic                        rsp_ready_i,
  output logic [MAX_CHAR-1:0]         rsp_data_o,
  output logic                        clg_enable_o,
  output logic                        clg_go_o,
  output logic                        clg_last_o,
  output logic [DIV_W-1:0]            clg_divider_o,
  input  logic                        clg_pos_edge_i,
  input  logic                        clg_neg_edge_i,
  output logic                        mosi_o,
  input  logic                        miso_i,
  output logic                        cs_no,
  output logic                        busy_o
`ifdef SPI_XFER_CTRL_IRQ_EN
  ,
  output logic                        irq_o
`endif
);

  localparam int LW = $clog2(MAX_CHAR);
  localparam int CW = LW + 1;

  state_t        state, state_next;
  logic [CW-1:0] tx_cnt, rx_cnt;
  logic [CW-1:0] len_full;
  logic          tx_neg, rx_neg;
  logic          rsp_valid;
  logic          accept, tx_edge, rx_edge, rx_final, advance;

  // A length of zero stands for a full MAX_CHAR-bit word.
  assign len_full = (req_len_i == '0) ? CW'(MAX_CHAR) : {1'b0, req_len_i};
  assign accept   = req_valid_i && req_ready_o;
  assign tx_edge  = (state == XFER) && (tx_neg ? clg_neg_edge_i : clg_pos_edge_i);
  assign rx_edge  = (state == XFER) && (rx_neg ? clg_neg_edge_i : clg_pos_edge_i);
  assign rx_final = rx_edge && (rx_cnt == CW'(1));
  assign advance  = tx_edge && (tx_cnt > CW'(1));

  assign rsp_valid_o = rsp_valid;

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_next   = state;
    req_ready_o  = 1'b0;
    cs_no        = 1'b1;
    clg_go_o     = 1'b0;
    clg_enable_o = 1'b0;
    clg_last_o   = 1'b0;
    busy_o       = 1'b1;
    unique case (state)
      IDLE: begin
        busy_o      = 1'b0;
        req_ready_o = !rsp_valid;
        if (req_valid_i && !rsp_valid) state_next = START;
      end
      START: begin
        cs_no        = 1'b0;
        clg_go_o     = 1'b1;
        clg_enable_o = 1'b1;
        state_next   = XFER;
      end
      XFER: begin
        cs_no        = 1'b0;
        clg_enable_o = 1'b1;
        clg_last_o   = (rx_cnt <= CW'(1));
        if (rx_final) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bit counters and per-transfer configuration latched on acceptance.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_cnt        <= '0;
      rx_cnt        <= '0;
      tx_neg        <= 1'b0;
      rx_neg        <= 1'b0;
      clg_divider_o <= '0;
    end else if (accept) begin
      tx_cnt        <= len_full;
      rx_cnt        <= len_full;
      tx_neg        <= req_tx_neg_i;
      rx_neg        <= req_rx_neg_i;
      clg_divider_o <= req_div_i;
    end else begin
      if (advance) tx_cnt <= tx_cnt - CW'(1);
      if (rx_edge) rx_cnt <= rx_cnt - CW'(1);
    end
  end

  // Response valid: set on the final rx edge (entry to DONE), cleared on handshake.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                          rsp_valid <= 1'b0;
    else if (rx_final)                  rsp_valid <= 1'b1;
    else if (rsp_valid && rsp_ready_i)  rsp_valid <= 1'b0;
  end

`ifdef SPI_XFER_CTRL_IRQ_EN
  // Interrupt follows the response: raised entering DONE, dropped on handshake.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                          irq_o <= 1'b0;
    else if (rx_final)                  irq_o <= 1'b1;
    else if (rsp_valid && rsp_ready_i)  irq_o <= 1'b0;
  end
`endif

  spi_xfer_shift #(
    .MAX_CHAR (MAX_CHAR),
    .CW       (CW)
  ) u_shift (
    .clk       (clk_i),
    .rst       (rst_i),
    .load      (accept),
    .load_lsb  (req_lsb_i),
    .load_len  (len_full),
    .load_data (req_data_i),
    .advance   (advance),
    .sample    (rx_edge),
    .capture   (rx_final),
    .miso      (miso_i),
    .mosi      (mosi_o),
    .rsp_data  (rsp_data_o)
  );

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed testbench for spi_xfer_ctrl with a small SPI clock-generator model.
// Build with SPI_XFER_CTRL_IRQ_EN defined to also exercise irq_o.
module tb_spi_xfer_ctrl;

  localparam int MAX_CHAR = 32;
  localparam int DIV_W    = 16;
  localparam int LW       = 5;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic                req_valid_i;
  logic                req_ready_o;
  logic [LW-1:0]       req_len_i;
  logic [MAX_CHAR-1:0] req_data_i;
  logic [DIV_W-1:0]    req_div_i;
  logic                req_lsb_i, req_tx_neg_i, req_rx_neg_i;
  logic                rsp_valid_o, rsp_ready_i;
  logic [MAX_CHAR-1:0] rsp_data_o;
  logic                clg_enable_o, clg_go_o, clg_last_o;
  logic [DIV_W-1:0]    clg_divider_o;
  logic                clg_pos_edge_i, clg_neg_edge_i;
  logic                mosi_o, miso_i, cs_no, busy_o;
`ifdef SPI_XFER_CTRL_IRQ_EN
  logic                irq_o;
`endif

  logic loop_en, miso_val;
  assign miso_i = loop_en ? mosi_o : miso_val;

  int checks = 0;
  int fails  = 0;

  spi_xfer_ctrl #(.MAX_CHAR(MAX_CHAR), .DIV_W(DIV_W)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_len_i      (req_len_i),
    .req_data_i     (req_data_i),
    .req_div_i      (req_div_i),
    .req_lsb_i      (req_lsb_i),
    .req_tx_neg_i   (req_tx_neg_i),
    .req_rx_neg_i   (req_rx_neg_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_data_o     (rsp_data_o),
    .clg_enable_o   (clg_enable_o),
    .clg_go_o       (clg_go_o),
    .clg_last_o     (clg_last_o),
    .clg_divider_o  (clg_divider_o),
    .clg_pos_edge_i (clg_pos_edge_i),
    .clg_neg_edge_i (clg_neg_edge_i),
    .mosi_o         (mosi_o),
    .miso_i         (miso_i),
    .cs_no          (cs_no),
    .busy_o         (busy_o)
`ifdef SPI_XFER_CTRL_IRQ_EN
    ,
    .irq_o          (irq_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Clock-generator model: once enabled and past START, a pos pulse then a neg
  // pulse every 4 cycles (or both together every 2 cycles in model_both mode).
  // Outside that window the injected pulses are driven instead.
  logic [1:0] ph = 2'd0;
  logic       model_both = 1'b0;
  logic       inj_pos = 1'b0, inj_neg = 1'b0;

  always @(posedge clk_i) begin
    #1;
    if (clg_enable_o && !clg_go_o) begin
      ph = ph + 2'd1;
      if (model_both) begin
        clg_pos_edge_i = ph[0];
        clg_neg_edge_i = ph[0];
      end else begin
        clg_pos_edge_i = (ph == 2'd1);
        clg_neg_edge_i = (ph == 2'd3);
      end
    end else begin
      ph             = 2'd0;
      clg_pos_edge_i = inj_pos;
      clg_neg_edge_i = inj_neg;
    end
  end

  // Transfer monitor results.
  logic mosi_seen [0:127];
  int   rx_seen, last_edges, last_idx, cs_low;

  function automatic logic [31:0] pack_seen(input int n, input logic lsb);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) begin
      if (lsb) v[i] = mosi_seen[i];
      else     v[n-1-i] = mosi_seen[i];
    end
    return v;
  endfunction

  task automatic send_req(input logic [LW-1:0] len, input logic [31:0] data,
                          input logic [15:0] div, input logic lsb,
                          input logic txn, input logic rxn);
    logic ok = 1'b0;
    @(negedge clk_i);
    req_len_i    = len;
    req_data_i   = data;
    req_div_i    = div;
    req_lsb_i    = lsb;
    req_tx_neg_i = txn;
    req_rx_neg_i = rxn;
    req_valid_i  = 1'b1;
    for (int c = 0; c < 50; c++) begin
      if (req_ready_o) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL accept: req_ready_o never high within 50 cycles (required high)");
    end
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
  endtask

  // Runs from the cycle after acceptance until rsp_valid_o, recording mosi at
  // every rx edge and how many rx edges saw clg_last_o high.
  task automatic wait_done(input logic rxn, input int budget);
    logic ok = 1'b0;
    rx_seen = 0; last_edges = 0; last_idx = -1; cs_low = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk_i);
      if (rsp_valid_o) begin
        ok = 1'b1;
        break;
      end
      if (!cs_no) cs_low++;
      if (!cs_no && !clg_go_o && (rxn ? clg_neg_edge_i : clg_pos_edge_i)) begin
        if (rx_seen < 128) mosi_seen[rx_seen] = mosi_o;
        rx_seen++;
        if (clg_last_o) begin
          last_edges++;
          last_idx = rx_seen;
        end
      end
    end
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL done_timeout: rsp_valid_o low after %0d cycles (required high)", budget);
    end
  endtask

  // Called at a negedge with rsp_valid_o high: one-cycle ready pulse.
  task automatic consume();
    rsp_ready_i = 1'b1;
    @(posedge clk_i);
    #1 rsp_ready_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (rsp_valid_o !== 1'b0) begin
      fails++;
      $display("FAIL rsp_clear: rsp_valid_o=%b required 0", rsp_valid_o);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    checks++;
    if ({cs_no, mosi_o, rsp_valid_o, clg_enable_o, clg_go_o, clg_last_o, busy_o, req_ready_o}
        !== 8'b1000_0001) begin
      fails++;
      $display("FAIL reset_ctrl: {cs,mosi,rv,en,go,last,busy,rdy}=%b required 10000001",
               {cs_no, mosi_o, rsp_valid_o, clg_enable_o, clg_go_o, clg_last_o, busy_o, req_ready_o});
    end
    checks++;
    if (rsp_data_o !== 32'h0 || clg_divider_o !== 16'h0) begin
      fails++;
      $display("FAIL reset_data: rsp_data=%h div=%h required 0/0", rsp_data_o, clg_divider_o);
    end
    rst_i = 1'b0;
  endtask

  task automatic test_msb_loopback();
    loop_en = 1'b1;
    send_req(5'd8, 32'hA5, 16'h0003, 1'b0, 1'b1, 1'b0);
    wait_done(1'b0, 200);
    checks++;
    if (pack_seen(8, 1'b0) !== 32'hA5) begin
      fails++;
      $display("FAIL msb_mosi_seq: %h required 000000a5", pack_seen(8, 1'b0));
    end
    checks++;
    if (rx_seen !== 8) begin
      fails++;
      $display("FAIL msb_rx_edges: %0d required 8", rx_seen);
    end
    checks++;
    if (cs_low !== 30) begin
      fails++;
      $display("FAIL msb_cs_low: %0d cycles required 30", cs_low);
    end
    checks++;
    if (rsp_data_o !== 32'hA5 || cs_no !== 1'b1) begin
      fails++;
      $display("FAIL msb_rsp: data=%h cs_no=%b required 000000a5/1", rsp_data_o, cs_no);
    end
    consume();
    checks++;
    if (clg_divider_o !== 16'h0003 || req_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL msb_idle: div=%h rdy=%b required 0003/1", clg_divider_o, req_ready_o);
    end
  endtask

  task automatic test_lsb_32();
    loop_en  = 1'b0;
    miso_val = 1'b1;
    send_req(5'd0, 32'h1234_5678, 16'h0001, 1'b1, 1'b1, 1'b0);
    wait_done(1'b0, 400);
    checks++;
    if (rx_seen !== 32 || cs_low !== 126) begin
      fails++;
      $display("FAIL lsb32_edges: edges=%0d cs_low=%0d required 32/126", rx_seen, cs_low);
    end
    checks++;
    if (last_edges !== 1 || last_idx !== 32) begin
      fails++;
      $display("FAIL lsb32_last: count=%0d idx=%0d required 1/32", last_edges, last_idx);
    end
    checks++;
    if (pack_seen(32, 1'b1) !== 32'h1234_5678) begin
      fails++;
      $display("FAIL lsb32_mosi_seq: %h required 12345678", pack_seen(32, 1'b1));
    end
    checks++;
    if (rsp_data_o !== 32'hFFFF_FFFF) begin
      fails++;
      $display("FAIL lsb32_rsp: %h required ffffffff", rsp_data_o);
    end
    consume();
  endtask

  task automatic test_same_cycle_edges();
    loop_en    = 1'b1;
    model_both = 1'b1;
    send_req(5'd8, 32'h3C, 16'h0002, 1'b1, 1'b1, 1'b0);
    wait_done(1'b0, 200);
    model_both = 1'b0;
    checks++;
    if (pack_seen(8, 1'b1) !== 32'h3C || cs_low !== 16) begin
      fails++;
      $display("FAIL both_seq: mosi=%h cs_low=%0d required 0000003c/16", pack_seen(8, 1'b1), cs_low);
    end
    checks++;
    if (rsp_data_o !== 32'h3C) begin
      fails++;
      $display("FAIL both_rsp: %h required 0000003c", rsp_data_o);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    loop_en = 1'b1;
    send_req(5'd5, 32'h13, 16'h0004, 1'b0, 1'b1, 1'b0);
    wait_done(1'b0, 200);
    checks++;
    if (pack_seen(5, 1'b0) !== 32'h13 || cs_low !== 18 || rsp_data_o !== 32'h13) begin
      fails++;
      $display("FAIL len5: mosi=%h cs_low=%0d rsp=%h required 00000013/18/00000013",
               pack_seen(5, 1'b0), cs_low, rsp_data_o);
    end
    // Hold the response unconsumed while a new request waits.
    req_len_i   = 5'd8;
    req_data_i  = 32'h5A;
    req_lsb_i   = 1'b0;
    req_valid_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      if (req_ready_o !== 1'b0 || rsp_valid_o !== 1'b1 || busy_o !== 1'b0 ||
          rsp_data_o !== 32'h13) bad++;
    end
    checks++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL hold: %0d cycles with ready/valid/busy/data wrong, required 0", bad);
    end
    rsp_ready_i = 1'b1;
    @(posedge clk_i);
    #1 rsp_ready_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0) begin
      fails++;
      $display("FAIL release: rdy=%b rv=%b required 1/0", req_ready_o, rsp_valid_o);
    end
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    wait_done(1'b0, 200);
    checks++;
    if (rsp_data_o !== 32'h5A || pack_seen(8, 1'b0) !== 32'h5A) begin
      fails++;
      $display("FAIL b2b_rsp: rsp=%h mosi=%h required 0000005a/0000005a", rsp_data_o, pack_seen(8, 1'b0));
    end
    consume();
  endtask

  task automatic test_reset_mid();
    int edges = 0;
    loop_en = 1'b1;
    send_req(5'd8, 32'hC3, 16'h0007, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 100 && edges < 4; c++) begin
      @(negedge clk_i);
      if (!cs_no && !clg_go_o && clg_pos_edge_i) edges++;
    end
    checks++;
    if (edges !== 4) begin
      fails++;
      $display("FAIL mid_edges: %0d required 4", edges);
    end
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    checks++;
    if ({cs_no, mosi_o, rsp_valid_o, clg_enable_o, clg_go_o, clg_last_o, busy_o, req_ready_o}
        !== 8'b1000_0001) begin
      fails++;
      $display("FAIL mid_reset_ctrl: {cs,mosi,rv,en,go,last,busy,rdy}=%b required 10000001",
               {cs_no, mosi_o, rsp_valid_o, clg_enable_o, clg_go_o, clg_last_o, busy_o, req_ready_o});
    end
    checks++;
    if (rsp_data_o !== 32'h0 || clg_divider_o !== 16'h0) begin
      fails++;
      $display("FAIL mid_reset_data: rsp=%h div=%h required 0/0", rsp_data_o, clg_divider_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    send_req(5'd8, 32'h96, 16'h0002, 1'b0, 1'b1, 1'b0);
    wait_done(1'b0, 200);
    checks++;
    if (rsp_data_o !== 32'h96 || rx_seen !== 8) begin
      fails++;
      $display("FAIL mid_recover: rsp=%h edges=%0d required 00000096/8", rsp_data_o, rx_seen);
    end
    consume();
  endtask

  task automatic test_spurious();
    int   bad = 0;
    logic m0;
    loop_en = 1'b1;
    @(negedge clk_i);
    m0 = mosi_o;
    inj_pos = 1'b1;
    inj_neg = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_i);
      if (mosi_o !== m0 || busy_o !== 1'b0 || rsp_valid_o !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL idle_spurious: %0d cycles disturbed, required 0", bad);
    end
    // Pulses stay injected through START and DONE of this transfer.
    send_req(5'd8, 32'h69, 16'h0002, 1'b0, 1'b1, 1'b0);
    wait_done(1'b0, 200);
    m0 = mosi_o;
    checks++;
    if (rsp_data_o !== 32'h69 || rx_seen !== 8 || pack_seen(8, 1'b0) !== 32'h69) begin
      fails++;
      $display("FAIL start_spurious: rsp=%h edges=%0d mosi=%h required 00000069/8/00000069",
               rsp_data_o, rx_seen, pack_seen(8, 1'b0));
    end
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      if (mosi_o !== m0 || rsp_data_o !== 32'h69 || busy_o !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL done_spurious: %0d cycles disturbed, required 0", bad);
    end
    inj_pos = 1'b0;
    inj_neg = 1'b0;
    consume();
    send_req(5'd8, 32'h0F, 16'h0002, 1'b0, 1'b1, 1'b0);
    wait_done(1'b0, 200);
    checks++;
    if (rsp_data_o !== 32'h0F || rx_seen !== 8) begin
      fails++;
      $display("FAIL post_spurious: rsp=%h edges=%0d required 0000000f/8", rsp_data_o, rx_seen);
    end
    consume();
  endtask

`ifdef SPI_XFER_CTRL_IRQ_EN
  task automatic test_irq();
    loop_en = 1'b1;
    send_req(5'd8, 32'hE1, 16'h0002, 1'b0, 1'b1, 1'b0);
    wait_done(1'b0, 200);
    checks++;
    if (irq_o !== 1'b1) begin
      fails++;
      $display("FAIL irq_set: irq_o=%b required 1", irq_o);
    end
    consume();
    checks++;
    if (irq_o !== 1'b0) begin
      fails++;
      $display("FAIL irq_clear: irq_o=%b required 0", irq_o);
    end
  endtask
`endif

  initial begin
    rst_i          = 1'b1;
    req_valid_i    = 1'b0;
    req_len_i      = '0;
    req_data_i     = '0;
    req_div_i      = '0;
    req_lsb_i      = 1'b0;
    req_tx_neg_i   = 1'b0;
    req_rx_neg_i   = 1'b0;
    rsp_ready_i    = 1'b0;
    clg_pos_edge_i = 1'b0;
    clg_neg_edge_i = 1'b0;
    loop_en        = 1'b0;
    miso_val       = 1'b0;

    test_reset();
    test_msb_loopback();
    test_lsb_32();
    test_same_cycle_edges();
    test_back_to_back();
    test_reset_mid();
    test_spurious();
`ifdef SPI_XFER_CTRL_IRQ_EN
    test_irq();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
